// File: rtl/chase_supervisor.sv
// chase_supervisor
// Frame-rate supervisor between the ball detector and the motor driver.
// It qualifies detections, runs an IDLE/ACQUIRE/TRACK/LOST/SEARCH sequencer,
// gates the PD controller's frame strobe, and produces the motor speed/turn.
//
// Build option:
//   CHASE_SUPERVISOR_SLEW_EN  defined   -> each output moves toward its target
//                                          by at most SLEW_STEP per frame.
//                             undefined -> each output loads its target directly
//                                          on a frame, saturated to +/-255.
// Dropping enable_in forces both outputs to 0 on the next cycle in both builds.
module chase_supervisor #(
    parameter int ACQ_FRAMES  = 3,
    parameter int LOST_FRAMES = 8,
    parameter int MIN_RAD     = 4,
    parameter int SEARCH_TURN = 64,
    parameter int SLEW_STEP   = 16
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              enable_in,
    input  logic              ready_in,
    input  logic              found_in,
    input  logic [6:0]        cur_rad,
    input  logic signed [8:0] speed_in,
    input  logic signed [8:0] turn_in,
    output logic              ctrl_ready_out,
    output logic signed [8:0] speed_out,
    output logic signed [8:0] turn_out,
    output logic [2:0]        state_out,
    output logic              lost_out
);

    localparam int HIT_W  = $clog2(ACQ_FRAMES + 1);
    localparam int MISS_W = $clog2(LOST_FRAMES + 1);

    localparam logic [HIT_W-1:0]   ACQ_N      = HIT_W'(ACQ_FRAMES);
    localparam logic [MISS_W-1:0]  LOST_N     = MISS_W'(LOST_FRAMES);
    localparam logic [6:0]         MIN_RAD_C  = 7'(MIN_RAD);
    localparam logic signed [8:0]  SEARCH_T   = 9'(SEARCH_TURN);
    localparam logic signed [9:0]  STEP_LIM   = 10'(SLEW_STEP);
    localparam logic signed [9:0]  OUT_MAX    = 10'sd255;
    localparam logic signed [9:0]  OUT_MIN    = -10'sd255;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACQUIRE = 3'd1,
        ST_TRACK   = 3'd2,
        ST_LOST    = 3'd3,
        ST_SEARCH  = 3'd4
    } state_t;

    // Registered state
    state_t              r_state;
    logic [HIT_W-1:0]    r_hit_cnt;
    logic [MISS_W-1:0]   r_miss_cnt;
    logic signed [8:0]   r_hold_speed;
    logic signed [8:0]   r_hold_turn;
    logic signed [8:0]   r_speed;
    logic signed [8:0]   r_turn;
    logic                r_ctrl_ready;
    logic                r_lost;

    // Combinational helpers
    logic                w_hit;
    logic                w_miss;
    logic [HIT_W-1:0]    w_hit_inc;
    logic [MISS_W-1:0]   w_miss_inc;
    state_t              w_state_nxt;
    logic [HIT_W-1:0]    w_hit_nxt;
    logic [MISS_W-1:0]   w_miss_nxt;
    logic                w_ctrl_nxt;
    logic signed [8:0]   w_tgt_speed;
    logic signed [8:0]   w_tgt_turn;
    logic signed [8:0]   w_step_speed;
    logic signed [8:0]   w_step_turn;

    // Move one output toward its target for a single frame and keep the
    // result inside the symmetric motor range [-255, 255].
    function automatic logic signed [8:0] step_out(
        input logic signed [8:0] cur,
        input logic signed [8:0] tgt
    );
        logic signed [9:0] cur_x;
        logic signed [9:0] tgt_x;
        logic signed [9:0] diff;
        logic signed [9:0] sum;
        logic signed [8:0] res;
        cur_x = cur;
        tgt_x = tgt;
`ifdef CHASE_SUPERVISOR_SLEW_EN
        diff = tgt_x - cur_x;
        if (diff > STEP_LIM) begin
            diff = STEP_LIM;
        end else if (diff < -STEP_LIM) begin
            diff = -STEP_LIM;
        end else begin
            diff = diff;
        end
        sum = cur_x + diff;
`else
        diff = 10'sd0;
        sum  = tgt_x + diff;
`endif
        if (sum > OUT_MAX) begin
            res = 9'sd255;
        end else if (sum < OUT_MIN) begin
            res = -9'sd255;
        end else begin
            res = sum[8:0];
        end
        return res;
    endfunction

    // Frame classification and saturating counter increments
    always_comb begin
        w_hit      = ready_in & found_in & (cur_rad >= MIN_RAD_C);
        w_miss     = ready_in & ~w_hit;
        w_hit_inc  = (r_hit_cnt  == {HIT_W{1'b1}})  ? r_hit_cnt  : r_hit_cnt  + 1'b1;
        w_miss_inc = (r_miss_cnt == {MISS_W{1'b1}}) ? r_miss_cnt : r_miss_cnt + 1'b1;
    end

    // Per-state drive target; LOST coasts on the last tracked command
    always_comb begin
        w_tgt_speed = 9'sd0;
        w_tgt_turn  = 9'sd0;
        case (r_state)
            ST_IDLE: begin
                w_tgt_speed = 9'sd0;
                w_tgt_turn  = 9'sd0;
            end
            ST_ACQUIRE: begin
                w_tgt_speed = 9'sd0;
                w_tgt_turn  = 9'sd0;
            end
            ST_TRACK: begin
                w_tgt_speed = speed_in;
                w_tgt_turn  = turn_in;
            end
            ST_LOST: begin
                w_tgt_speed = r_hold_speed;
                w_tgt_turn  = r_hold_turn;
            end
            ST_SEARCH: begin
                w_tgt_speed = 9'sd0;
                w_tgt_turn  = SEARCH_T;
            end
            default: begin
                w_tgt_speed = 9'sd0;
                w_tgt_turn  = 9'sd0;
            end
        endcase
        w_step_speed = step_out(r_speed, w_tgt_speed);
        w_step_turn  = step_out(r_turn,  w_tgt_turn);
    end

    // Sequencer next-state, counter and controller-strobe decisions
    always_comb begin
        w_state_nxt = r_state;
        w_hit_nxt   = r_hit_cnt;
        w_miss_nxt  = r_miss_cnt;
        w_ctrl_nxt  = 1'b0;
        if (!enable_in) begin
            w_state_nxt = ST_IDLE;
            w_hit_nxt   = '0;
            w_miss_nxt  = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_ACQUIRE;
                    w_hit_nxt   = '0;
                    w_miss_nxt  = '0;
                end
                ST_ACQUIRE: begin
                    if (w_hit) begin
                        w_ctrl_nxt = 1'b1;
                        if (w_hit_inc == ACQ_N) begin
                            w_state_nxt = ST_TRACK;
                            w_hit_nxt   = '0;
                        end else begin
                            w_hit_nxt = w_hit_inc;
                        end
                    end else if (w_miss) begin
                        w_hit_nxt = '0;
                    end else begin
                        w_hit_nxt = r_hit_cnt;
                    end
                end
                ST_TRACK: begin
                    if (w_hit) begin
                        w_ctrl_nxt = 1'b1;
                    end else if (w_miss) begin
                        w_state_nxt = ST_LOST;
                        w_miss_nxt  = MISS_W'(1);
                    end else begin
                        w_state_nxt = ST_TRACK;
                    end
                end
                ST_LOST: begin
                    if (w_hit) begin
                        w_ctrl_nxt  = 1'b1;
                        w_state_nxt = ST_TRACK;
                        w_miss_nxt  = '0;
                    end else if (w_miss) begin
                        if (w_miss_inc >= LOST_N) begin
                            w_state_nxt = ST_SEARCH;
                            w_miss_nxt  = '0;
                        end else begin
                            w_miss_nxt = w_miss_inc;
                        end
                    end else begin
                        w_miss_nxt = r_miss_cnt;
                    end
                end
                ST_SEARCH: begin
                    // No controller strobe here: its position history is stale.
                    if (w_hit) begin
                        if (ACQ_N == HIT_W'(1)) begin
                            w_state_nxt = ST_TRACK;
                            w_hit_nxt   = '0;
                        end else begin
                            w_state_nxt = ST_ACQUIRE;
                            w_hit_nxt   = HIT_W'(1);
                        end
                    end else begin
                        w_state_nxt = ST_SEARCH;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_hit_nxt   = '0;
                    w_miss_nxt  = '0;
                end
            endcase
        end
    end

    // Sequencer registers and registered motor/strobe outputs
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state      <= ST_IDLE;
            r_hit_cnt    <= '0;
            r_miss_cnt   <= '0;
            r_hold_speed <= 9'sd0;
            r_hold_turn  <= 9'sd0;
            r_speed      <= 9'sd0;
            r_turn       <= 9'sd0;
            r_ctrl_ready <= 1'b0;
            r_lost       <= 1'b0;
        end else if (!enable_in) begin
            r_state      <= ST_IDLE;
            r_hit_cnt    <= '0;
            r_miss_cnt   <= '0;
            r_hold_speed <= 9'sd0;
            r_hold_turn  <= 9'sd0;
            r_speed      <= 9'sd0;
            r_turn       <= 9'sd0;
            r_ctrl_ready <= 1'b0;
            r_lost       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_hit_cnt    <= w_hit_nxt;
            r_miss_cnt   <= w_miss_nxt;
            r_ctrl_ready <= w_ctrl_nxt;
            r_lost       <= (w_state_nxt == ST_LOST) || (w_state_nxt == ST_SEARCH);
            if (ready_in) begin
                r_speed <= w_step_speed;
                r_turn  <= w_step_turn;
            end else begin
                r_speed <= r_speed;
                r_turn  <= r_turn;
            end
            if (ready_in && (r_state == ST_TRACK)) begin
                r_hold_speed <= speed_in;
                r_hold_turn  <= turn_in;
            end else begin
                r_hold_speed <= r_hold_speed;
                r_hold_turn  <= r_hold_turn;
            end
        end
    end

    assign ctrl_ready_out = r_ctrl_ready;
    assign speed_out      = r_speed;
    assign turn_out       = r_turn;
    assign state_out      = r_state;
    assign lost_out       = r_lost;

endmodule

// File: doc/chase_supervisor.md
# chase_supervisor

Frame-rate supervisor that sequences the PD drive controller. It qualifies per-frame detections, runs an acquire/track/lost/search state machine and gates the controller's derivative updates. It also slew-limits the controller's speed/turn commands before they reach the motor driver, and sits between the ball detector (frame strobe, radius) and the motor interface.

## Interface
Parameters:
- ACQ_FRAMES, 3: consecutive qualifying hits needed to enter TRACK (≥1).
- LOST_FRAMES, 8: consecutive misses in LOST before entering SEARCH (≥1).
- MIN_RAD, 4: minimum cur_rad counted as a hit.
- SEARCH_TURN, 64: signed turn target in SEARCH.
- SLEW_STEP, 16: max per-frame change of each output (1..255).

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  reset; asynchronous, active-high.
- enable_in  in  1  drive enable; low forces IDLE.
- ready_in  in  1  one-cycle frame strobe from detector.
- found_in  in  1  target detected this frame; valid with ready_in.
- cur_rad  in  7  detected radius; valid with ready_in.
- speed_in  in  9 signed  speed command from PD controller.
- turn_in  in  9 signed  turn command from PD controller.
- ctrl_ready_out  out  1  qualified-frame pulse to PD controller's ready_in.
- speed_out  out  9 signed  motor speed.
- turn_out  out  9 signed  motor turn.
- state_out  out  3  current state encoding.
- lost_out  out  1  high in LOST or SEARCH.

## Operation
- States: IDLE=0, ACQUIRE=1, TRACK=2, LOST=3, SEARCH=4; codes 5–7 are unreachable and recover to IDLE.
- Frame event: a cycle with ready_in=1. Hit: frame event with found_in=1 and cur_rad ≥ MIN_RAD. Miss: any other frame event.
- enable_in=0, any state: next state is IDLE, counters are cleared, and speed_out/turn_out are forced to 0 next cycle without slew. This takes priority over a simultaneous frame event.
- IDLE: with enable_in=1, go to ACQUIRE (no frame needed). Target 0/0.
- ACQUIRE: a hit increments hit_cnt; a miss clears it. When a hit brings hit_cnt to ACQ_FRAMES, go to TRACK. Target 0/0.
- TRACK: target is speed_in/turn_in. A miss goes to LOST with miss_cnt=1.
- LOST: holds the last targets (coast). A hit goes to TRACK and clears miss_cnt. A miss increments miss_cnt; when it reaches LOST_FRAMES, go to SEARCH.
- SEARCH: target speed 0, turn SEARCH_TURN. A hit goes to ACQUIRE with hit_cnt=1, or straight to TRACK if ACQ_FRAMES=1.
- hit_cnt and miss_cnt saturate and never wrap.
- ctrl_ready_out: pulses for a hit frame in ACQUIRE, TRACK or LOST. It never pulses in IDLE or SEARCH, so a stale position cannot corrupt the controller's derivative term.
- Output update happens on frame events only; outputs hold between frames.
  - Compute diff = target − out in 10-bit signed.
  - Clamp diff to ±SLEW_STEP, add it to out, then saturate the result to [−255, 255].

## Timing
- Reset (asynchronous): state IDLE, counters 0, speed_out=0, turn_out=0, ctrl_ready_out=0, lost_out=0, state_out=0.
- State, counters and outputs are registered; a frame event at cycle N takes effect at N+1.
- ctrl_ready_out is high for exactly cycle N+1 after a qualifying hit at N.
- Outputs use the speed_in/turn_in values present at cycle N, which are the controller's result for the previous qualified frame.
- Back-to-back ready_in on consecutive cycles is legal; each pulse is processed as a separate frame.
- Reset asserted mid-frame, or mid-slew, returns everything to reset values immediately; there is no partial update.

## Configuration
- CHASE_SUPERVISOR_SLEW_EN defined: slew limiting as described.
- CHASE_SUPERVISOR_SLEW_EN undefined: on each frame event, outputs load the target directly, saturated to ±255.
- enable_in forcing outputs to 0 behaves the same either way.

## Test plan
- Reset, then enable_in=1 and 3 hits at cur_rad=20 → state_out goes 0→1→2 after the third frame; ctrl_ready_out pulses 3 times.
- In TRACK with speed_in=100 and outputs at 0, apply 7 frames → speed_out steps 16, 32, …, 96, 100 (slew build only).
- In TRACK, 1 miss then 8 misses → LOST with outputs held, then SEARCH with turn_out ramping by 16 to 64 and lost_out=1.
- In SEARCH, a hit at cur_rad=3 → stays SEARCH with no ctrl_ready_out; a hit at cur_rad=10 → ACQUIRE.
- enable_in dropped on the same cycle as a hit in TRACK with speed_out=80 → next cycle state 0, speed_out=0, no ctrl_ready_out.
- rst_in asserted mid-ramp asynchronously (between clock edges) → all outputs 0 before the next clock edge.
